ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port word RAM. Accepts read, full-word write and byte-masked write requests from two masters (m0, m1), e.g. instruction fetch and load/store, and serialises them onto the RAM port. The RAM writes only full words, so the arbiter performs read-modify-write for partial byte-enable writes. Sits directly between the core's memory interfaces and the RAM instance.

---
 rtl/ram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter/sequencer for a single-port word RAM.
// Serialises reads, full writes and byte-masked writes (via read-modify-write).
module ram_arbiter #(
    parameter int unsigned SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_we_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_we_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic [31:0] ram_addr_o,
    output logic        ram_en_o,
    output logic [3:0]  ram_we_o,
    output logic [31:0] ram_din_o,
    input  logic [31:0] ram_dout_i
);

    typedef enum logic [1:0] {StIdle, StMerge, StAck} state_e;

    state_e      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;  // 1: m1 was granted last
    logic        owner_q, owner_d;
    logic [29:0] word_q, word_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic        any_req;
    logic        sel;
    logic [31:0] req_addr;
    logic [3:0]  req_we;
    logic [31:0] req_wdata;
    logic [29:0] req_word;
    logic        req_oor;
    logic [31:0] ack_rdata;

    // On a tie the master not granted last wins; otherwise the sole requester.
    always_comb begin
        any_req   = m0_req_i | m1_req_i;
        sel       = (m0_req_i && m1_req_i) ? ~last_gnt_q : m1_req_i;
        req_addr  = sel ? m1_addr_i : m0_addr_i;
        req_we    = sel ? m1_we_i : m0_we_i;
        req_wdata = sel ? m1_wdata_i : m0_wdata_i;
        req_word  = req_addr[31:2];
        req_oor   = {2'b00, req_word} >= SIZE;
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        word_d     = word_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        err_d      = err_q;

        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        m0_err_o    = 1'b0;
        m1_err_o    = 1'b0;
        ram_addr_o  = '0;
        ram_en_o    = 1'b0;
        ram_we_o    = 4'h0;
        ram_din_o   = '0;
        ack_rdata   = '0;

        // Reset overrides everything in the same cycle; nothing reaches the RAM.
        if (!rst_i) begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        m0_gnt_o   = ~sel;
                        m1_gnt_o   = sel;
                        last_gnt_d = sel;
                        owner_d    = sel;
                        word_d     = req_word;
                        we_d       = req_we;
                        wdata_d    = req_wdata;
                        err_d      = req_oor;
                        if (req_oor) begin
                            state_d = StAck;
                        end else begin
                            ram_en_o   = 1'b1;
                            ram_addr_o = {req_word, 2'b00};
                            if (req_we == 4'hF) begin
                                ram_we_o  = 4'hF;
                                ram_din_o = req_wdata;
                                state_d   = StAck;
                            end else if (req_we == 4'h0) begin
                                state_d = StAck;
                            end else begin
                                state_d = StMerge;
                            end
                        end
                    end
                end
                StMerge: begin
                    ram_en_o   = 1'b1;
                    ram_we_o   = 4'hF;
                    ram_addr_o = {word_q, 2'b00};
                    for (int k = 0; k < 4; k++) begin
                        ram_din_o[8*k +: 8] = we_q[k] ? wdata_q[8*k +: 8]
                                                      : ram_dout_i[8*k +: 8];
                    end
                    state_d = StAck;
                end
                StAck: begin
                    ack_rdata = (we_q == 4'h0 && !err_q) ? ram_dout_i : 32'h0;
                    if (owner_q) begin
                        m1_rvalid_o = 1'b1;
                        m1_rdata_o  = ack_rdata;
                        m1_err_o    = err_q;
                    end else begin
                        m0_rvalid_o = 1'b1;
                        m0_rdata_o  = ack_rdata;
                        m0_err_o    = err_q;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            word_q     <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            word_q     <= word_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-output RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] ram_addr, ram_din;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_dout = 32'h0;
    logic [31:0] mem [0:1023];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.SIZE(1024)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .m0_req_i   (m0_req),
        .m0_addr_i  (m0_addr),
        .m0_we_i    (m0_we),
        .m0_wdata_i (m0_wdata),
        .m0_gnt_o   (m0_gnt),
        .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o (m0_rdata),
        .m0_err_o   (m0_err),
        .m1_req_i   (m1_req),
        .m1_addr_i  (m1_addr),
        .m1_we_i    (m1_we),
        .m1_wdata_i (m1_wdata),
        .m1_gnt_o   (m1_gnt),
        .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o (m1_rdata),
        .m1_err_o   (m1_err),
        .ram_addr_o (ram_addr),
        .ram_en_o   (ram_en),
        .ram_we_o   (ram_we),
        .ram_din_o  (ram_din),
        .ram_dout_i (ram_dout)
    );

    // Read-first single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'hF) mem[ram_addr[11:2]] <= ram_din;
            ram_dout <= mem[ram_addr[11:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic gnt_of(input int m);
        return (m != 0) ? m1_gnt : m0_gnt;
    endfunction
    function automatic logic rvalid_of(input int m);
        return (m != 0) ? m1_rvalid : m0_rvalid;
    endfunction
    function automatic logic [31:0] rdata_of(input int m);
        return (m != 0) ? m1_rdata : m0_rdata;
    endfunction
    function automatic logic err_of(input int m);
        return (m != 0) ? m1_err : m0_err;
    endfunction

    task automatic set_req(input int m, input logic r, input logic [31:0] a,
                           input logic [3:0] we, input logic [31:0] d);
        if (m != 0) begin
            m1_req = r; m1_addr = a; m1_we = we; m1_wdata = d;
        end else begin
            m0_req = r; m0_addr = a; m0_we = we; m0_wdata = d;
        end
    endtask

    task automatic wait_gnt(input string tag, input int m, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (gnt_of(m)) begin
                ok = 1'b1;
                return;
            end
        end
        check({tag, "/gnt_timeout"}, 32'(gnt_of(m)), 32'h1);
    endtask

    // One complete transaction; exp_din is the merged word for partial writes.
    task automatic txn(input string tag, input int m, input logic [31:0] a,
                       input logic [3:0] we, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [31:0] exp_din);
        bit ok;
        bit partial;
        bit full;
        partial = !exp_err && we != 4'h0 && we != 4'hF;
        full    = !exp_err && we == 4'hF;
        set_req(m, 1'b1, a, we, d);
        wait_gnt(tag, m, ok);
        if (ok) begin
            check({tag, "/gnt_other"}, 32'(gnt_of(1 - m)), 32'h0);
            check({tag, "/en_t"}, 32'(ram_en), 32'(!exp_err));
            check({tag, "/we_t"}, 32'(ram_we), full ? 32'hF : 32'h0);
            if (full) check({tag, "/din_t"}, ram_din, d);
        end
        @(posedge clk); #1;
        set_req(m, 1'b0, 32'h0, 4'h0, 32'h0);
        if (partial) begin
            @(negedge clk);
            check({tag, "/we_merge"}, 32'(ram_we), 32'hF);
            check({tag, "/din_merge"}, ram_din, exp_din);
            check({tag, "/rv_early"}, 32'(rvalid_of(m)), 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({tag, "/rvalid"}, 32'(rvalid_of(m)), 32'h1);
        check({tag, "/rv_other"}, 32'(rvalid_of(1 - m)), 32'h0);
        check({tag, "/rdata"}, rdata_of(m), exp_rdata);
        check({tag, "/err"}, 32'(err_of(m)), 32'(exp_err));
        check({tag, "/en_ack"}, {31'h0, ram_en} | {31'h0, m0_gnt | m1_gnt}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_i = 1'b1;
        set_req(0, 1'b1, 32'h0, 4'h0, 32'h0);
        set_req(1, 1'b1, 32'h4, 4'h0, 32'h0);

        repeat (3) begin
            @(negedge clk);
            check("rst_ctl", {24'h0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid,
                              m1_err, m0_err, ram_en, ram_we != 4'h0}, 32'h0);
            check("rst_data", m0_rdata | m1_rdata | ram_addr | ram_din, 32'h0);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("first_tie_m0", {30'h0, m1_gnt, m0_gnt}, 32'h1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_req(1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("first_ack", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);
        @(posedge clk); #1;

        txn("wr_full", 0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0);
        txn("rd_back", 0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0);
        txn("wr_part", 1, 32'h10, 4'b0101, 32'h00AA0055, 32'h0, 1'b0, 32'hDEAABE55);
        txn("rd_part", 1, 32'h10, 4'h0, 32'h0, 32'hDEAABE55, 1'b0, 32'h0);
        txn("wr_14", 0, 32'h14, 4'hF, 32'h5555AAAA, 32'h0, 1'b0, 32'h0);
        txn("wr_20", 1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, 32'h0);

        // Last grant went to m1, so continuous requests start with m0.
        set_req(0, 1'b1, 32'h10, 4'h0, 32'h0);
        set_req(1, 1'b1, 32'h14, 4'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                check("rr_gnt", {30'h0, m1_gnt, m0_gnt}, (i % 4 == 0) ? 32'h1 : 32'h2);
                check("rr_rv_idle", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
            end else begin
                check("rr_gnt_ack", {30'h0, m1_gnt, m0_gnt}, 32'h0);
                check("rr_rv", {30'h0, m1_rvalid, m0_rvalid}, (i % 4 == 1) ? 32'h1 : 32'h2);
                check("rr_rd0", m0_rdata, (i % 4 == 1) ? 32'hDEAABE55 : 32'h0);
                check("rr_rd1", m1_rdata, (i % 4 == 3) ? 32'h5555AAAA : 32'h0);
            end
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_req(1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;

        txn("oor_rd", 0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        txn("in_rd", 0, 32'h10, 4'h0, 32'h0, 32'hDEAABE55, 1'b0, 32'h0);
        txn("oor_part", 1, 32'h2000, 4'b0011, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0);
        txn("top_wr", 0, 32'hFFC, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 32'h0);
        txn("top_rd", 1, 32'hFFC, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0);

        begin : rst_in_merge
            bit ok;
            set_req(1, 1'b1, 32'h20, 4'b0011, 32'hFFFFFFFF);
            wait_gnt("rst_merge", 1, ok);
            @(posedge clk); #1;
            set_req(1, 1'b0, 32'h0, 4'h0, 32'h0);
            rst_i = 1'b1;
            @(negedge clk);
            check("rstm_ram", {30'h0, ram_en, ram_we != 4'h0}, 32'h0);
            check("rstm_rv", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
            @(posedge clk); #1;
            rst_i = 1'b0;
            @(negedge clk);
            check("rstm_after", {29'h0, ram_en, m1_rvalid, m0_rvalid}, 32'h0);
            @(posedge clk); #1;
        end
        txn("rstm_rd", 0, 32'h20, 4'h0, 32'h0, 32'h11223344, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
